// File: rtl/inst_queue_if.sv
// Fetch/decode-facing handshake bundle for inst_queue.
// Master is the fetch+decode side and slave is the queue.
interface inst_queue_if #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 106,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(ISSUE_W + 1);

  logic                       flush;
  logic                       in_en;
  logic [FETCH_W-1:0]         in_valid;
  logic [FETCH_W*ENTRY_W-1:0] in_data;
  logic [NW-1:0]              pop_num;
  logic [ISSUE_W*ENTRY_W-1:0] out_data;
  logic [ISSUE_W-1:0]         out_valid;
  logic [CW-1:0]              count;
  logic                       stall;

  modport master (
    output flush, in_en, in_valid, in_data, pop_num,
    input  out_data, out_valid, count, stall
  );

  modport slave (
    input  flush, in_en, in_valid, in_data, pop_num,
    output out_data, out_valid, count, stall
  );
endinterface

// File: rtl/inst_queue.sv
// Circular fetch-to-decode instruction queue with compacting multi-lane push and variable pop.
// Optional performance counters are enabled by defining INST_QUEUE_PERF_EN.
module inst_queue #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 106,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  inst_queue_if.slave bus
`ifdef INST_QUEUE_PERF_EN
  ,
  output logic [31:0] full_cycles,
  output logic [31:0] flush_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(ISSUE_W + 1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;

  logic                       stall_s;
  logic                       push_ok_s;
  logic [FETCH_W-1:0]         lane_we_s;
  logic [PW-1:0]              wr_idx_s [FETCH_W];
  logic [CW-1:0]              npush_s;
  logic [NW-1:0]              pop_req_s;
  logic [CW-1:0]              npop_s;
  logic [ISSUE_W*ENTRY_W-1:0] out_data_s;
  logic [ISSUE_W-1:0]         out_valid_s;

  // Stall looks only at registered occupancy so a pop never feeds the push path.
  assign stall_s = (CW'(DEPTH) - count_q) < CW'(FETCH_W);

  // Compacted write slots and clamped pop amount.
  always_comb begin
    npush_s   = '0;
    push_ok_s = bus.in_en & ~stall_s & ~bus.flush;
    for (int i = 0; i < FETCH_W; i++) begin
      lane_we_s[i] = push_ok_s & bus.in_valid[i];
      wr_idx_s[i]  = tail_q + npush_s[PW-1:0];
      npush_s      = npush_s + CW'(lane_we_s[i]);
    end
    if (bus.pop_num > NW'(ISSUE_W)) begin
      pop_req_s = NW'(ISSUE_W);
    end else begin
      pop_req_s = bus.pop_num;
    end
    if (CW'(pop_req_s) > count_q) begin
      npop_s = count_q;
    end else begin
      npop_s = CW'(pop_req_s);
    end
  end

  // Pointer and occupancy next state; flush wins over push and pop.
  always_comb begin
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + npop_s[PW-1:0];
      tail_d  = tail_q + npush_s[PW-1:0];
      count_d = count_q + npush_s - npop_s;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; left unreset since out_valid gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (lane_we_s[i]) begin
        mem_q[wr_idx_s[i]] <= bus.in_data[i*ENTRY_W +: ENTRY_W];
      end
    end
  end

  // Zero-latency read of the oldest ISSUE_W entries.
  always_comb begin
    for (int i = 0; i < ISSUE_W; i++) begin
      out_valid_s[i]                    = count_q > CW'(i);
      out_data_s[i*ENTRY_W +: ENTRY_W] = mem_q[head_q + PW'(i)];
    end
  end

  assign bus.out_data  = out_data_s;
  assign bus.out_valid = out_valid_s;
  assign bus.count     = count_q;
  assign bus.stall     = stall_s;

`ifdef INST_QUEUE_PERF_EN
  logic [31:0] full_cycles_q;
  logic [31:0] flush_cnt_q;

  // Stall-cycle and flush counters survive flush and wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_cycles_q <= 32'd0;
      flush_cnt_q   <= 32'd0;
    end else begin
      full_cycles_q <= full_cycles_q + {31'd0, stall_s};
      flush_cnt_q   <= flush_cnt_q + {31'd0, bus.flush};
    end
  end

  assign full_cycles = full_cycles_q;
  assign flush_cnt   = flush_cnt_q;
`endif
endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (DEPTH=8, FETCH_W=2, ISSUE_W=2).
module tb_inst_queue;
  localparam int DEPTH   = 8;
  localparam int ENTRY_W = 106;
  localparam int FETCH_W = 2;
  localparam int ISSUE_W = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  inst_queue_if #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)) bus ();

`ifdef INST_QUEUE_PERF_EN
  logic [31:0] full_cycles;
  logic [31:0] flush_cnt;
`endif

  inst_queue #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef INST_QUEUE_PERF_EN
    ,
    .full_cycles(full_cycles),
    .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entry layout: {valid, pred_taken, pred_addr[32], pc[32], inst[32], exc+cause[8]}; pc at [71:40].
  function automatic logic [ENTRY_W-1:0] mk(input logic [31:0] pc);
    return {1'b1, 1'b0, 32'h0, pc, 32'h00000013, 8'h00};
  endfunction

  function automatic logic [31:0] lane_pc(input int lane);
    logic [ISSUE_W*ENTRY_W-1:0] d;
    d = bus.out_data;
    return d[lane*ENTRY_W + 40 +: 32];
  endfunction

  function automatic logic lane_vbit(input int lane);
    logic [ISSUE_W*ENTRY_W-1:0] d;
    d = bus.out_data;
    return d[lane*ENTRY_W + ENTRY_W - 1];
  endfunction

  task automatic drive(input logic en, input logic [1:0] v, input logic [31:0] pc0,
                       input logic [31:0] pc1, input logic [1:0] pn, input logic fl);
    bus.in_en    = en;
    bus.in_valid = v;
    bus.in_data  = {mk(pc1), mk(pc0)};
    bus.pop_num  = pn;
    bus.flush    = fl;
    @(posedge clk);
    #1;
    bus.in_en    = 1'b0;
    bus.in_valid = 2'b00;
    bus.pop_num  = 2'd0;
    bus.flush    = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid got=%b exp=00", bus.out_valid); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 2'b11, 32'h1, 32'h2, 2'd0, 1'b0);
    checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL pre_midreset_count got=%0d exp=2", bus.count); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL midreset_async_count got=%0d exp=0", bus.count); end
    checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL midreset_out_valid got=%b exp=00", bus.out_valid); end
    #1;
    rst = 1'b1;
    drive(1'b1, 2'b11, 32'h3, 32'h4, 2'd0, 1'b0);
    checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL post_reset_push_count got=%0d exp=2", bus.count); end
    checks++; if (lane_pc(0) !== 32'h3) begin errors++; $display("FAIL post_reset_lane0 got=%h exp=3", lane_pc(0)); end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL post_reset_drain got=%0d exp=0", bus.count); end
  endtask

  task automatic test_push_basic;
    drive(1'b1, 2'b11, 32'h1c000000, 32'h1c000004, 2'd0, 1'b0);
    checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL basic_count got=%0d exp=2", bus.count); end
    checks++; if (bus.out_valid !== 2'b11) begin errors++; $display("FAIL basic_out_valid got=%b exp=11", bus.out_valid); end
    checks++; if (lane_pc(0) !== 32'h1c000000) begin errors++; $display("FAIL basic_lane0_pc got=%h exp=1c000000", lane_pc(0)); end
    checks++; if (lane_pc(1) !== 32'h1c000004) begin errors++; $display("FAIL basic_lane1_pc got=%h exp=1c000004", lane_pc(1)); end
    drive(1'b0, 2'b11, 32'h0, 32'h0, 2'd1, 1'b0);
    checks++; if (lane_pc(0) !== 32'h1c000004) begin errors++; $display("FAIL basic_pop1_lane0 got=%h exp=1c000004", lane_pc(0)); end
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL basic_en0_count got=%0d exp=1", bus.count); end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL basic_drain got=%0d exp=0", bus.count); end
  endtask

  task automatic test_compaction;
    drive(1'b1, 2'b10, 32'hdeadbeef, 32'h1c000014, 2'd0, 1'b0);
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL compact_count got=%0d exp=1", bus.count); end
    checks++; if (bus.out_valid !== 2'b01) begin errors++; $display("FAIL compact_out_valid got=%b exp=01", bus.out_valid); end
    checks++; if (lane_pc(0) !== 32'h1c000014) begin errors++; $display("FAIL compact_lane0_pc got=%h exp=1c000014", lane_pc(0)); end
    checks++; if (lane_vbit(0) !== 1'b1) begin errors++; $display("FAIL compact_valid_bit got=%b exp=1", lane_vbit(0)); end
    drive(1'b1, 2'b00, 32'h5, 32'h6, 2'd0, 1'b0);
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL en_novalid_count got=%0d exp=1", bus.count); end
    drive(1'b1, 2'b01, 32'h1c000018, 32'hbad, 2'd0, 1'b0);
    checks++; if (lane_pc(1) !== 32'h1c000018) begin errors++; $display("FAIL compact_lane1_pc got=%h exp=1c000018", lane_pc(1)); end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL compact_drain got=%0d exp=0", bus.count); end
  endtask

  task automatic test_full;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL fill_stall_%0d got=%b exp=0", k, bus.stall); end
      drive(1'b1, 2'b11, 32'h100 + 32'(8*k), 32'h104 + 32'(8*k), 2'd0, 1'b0);
      checks++; if (bus.count !== 4'(2*k+2)) begin errors++; $display("FAIL fill_count_%0d got=%0d exp=%0d", k, bus.count, 2*k+2); end
    end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL full_stall got=%b exp=1", bus.stall); end
    drive(1'b1, 2'b11, 32'h900, 32'h904, 2'd0, 1'b0);
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL full_drop_count got=%0d exp=8", bus.count); end
    checks++; if (lane_pc(0) !== 32'h100) begin errors++; $display("FAIL full_drop_lane0 got=%h exp=100", lane_pc(0)); end
    drive(1'b1, 2'b11, 32'h900, 32'h904, 2'd1, 1'b0);
    checks++; if (bus.count !== 4'd7) begin errors++; $display("FAIL full_pop1_count got=%0d exp=7", bus.count); end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL count7_stall got=%b exp=1", bus.stall); end
    drive(1'b1, 2'b11, 32'h900, 32'h904, 2'd1, 1'b0);
    checks++; if (bus.count !== 4'd6) begin errors++; $display("FAIL conservative_count got=%0d exp=6", bus.count); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL count6_stall got=%b exp=0", bus.stall); end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 2'd3, 1'b0);
    checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL popnum3_clamp got=%0d exp=4", bus.count); end
    checks++; if (lane_pc(0) !== 32'h110) begin errors++; $display("FAIL popnum3_lane0 got=%h exp=110", lane_pc(0)); end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL full_drain got=%0d exp=0", bus.count); end
  endtask

  task automatic test_wrap;
    logic [31:0] next_push;
    logic [31:0] exp_pop;
    next_push = 32'h2000;
    exp_pop   = 32'h2000;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b11, next_push, next_push + 32'd4, 2'd0, 1'b0);
      next_push = next_push + 32'd8;
    end
    for (int k = 0; k < 10; k++) begin
      checks++; if (lane_pc(0) !== exp_pop) begin errors++; $display("FAIL wrap_lane0_%0d got=%h exp=%h", k, lane_pc(0), exp_pop); end
      checks++; if (lane_pc(1) !== exp_pop + 32'd4) begin errors++; $display("FAIL wrap_lane1_%0d got=%h exp=%h", k, lane_pc(1), exp_pop + 32'd4); end
      drive(1'b1, 2'b11, next_push, next_push + 32'd4, 2'd2, 1'b0);
      next_push = next_push + 32'd8;
      exp_pop   = exp_pop + 32'd8;
      checks++; if (bus.count !== 4'd6) begin errors++; $display("FAIL wrap_count_%0d got=%0d exp=6", k, bus.count); end
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (lane_pc(0) !== exp_pop) begin errors++; $display("FAIL wrap_drain_%0d got=%h exp=%h", k, lane_pc(0), exp_pop); end
      drive(1'b0, 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
      exp_pop = exp_pop + 32'd8;
    end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL wrap_empty got=%0d exp=0", bus.count); end
  endtask

  task automatic test_underflow;
    drive(1'b1, 2'b01, 32'h3000, 32'h0, 2'd0, 1'b0);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL under_count got=%0d exp=0", bus.count); end
    checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL under_out_valid got=%b exp=00", bus.out_valid); end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL under_again got=%0d exp=0", bus.count); end
  endtask

  task automatic test_flush;
    drive(1'b1, 2'b11, 32'h4000, 32'h4004, 2'd0, 1'b0);
    drive(1'b1, 2'b11, 32'h4008, 32'h400c, 2'd0, 1'b0);
    drive(1'b1, 2'b01, 32'h4010, 32'h0, 2'd0, 1'b0);
    checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL preflush_count got=%0d exp=5", bus.count); end
    drive(1'b1, 2'b11, 32'h4014, 32'h4018, 2'd2, 1'b1);
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
    checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL flush_out_valid got=%b exp=00", bus.out_valid); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", bus.stall); end
`ifdef INST_QUEUE_PERF_EN
    checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL flush_cnt got=%0d exp=1", flush_cnt); end
    checks++; if (full_cycles !== 32'd3) begin errors++; $display("FAIL full_cycles got=%0d exp=3", full_cycles); end
`endif
    drive(1'b1, 2'b11, 32'h5000, 32'h5004, 2'd0, 1'b0);
    checks++; if (lane_pc(0) !== 32'h5000) begin errors++; $display("FAIL postflush_lane0 got=%h exp=5000", lane_pc(0)); end
    checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL postflush_count got=%0d exp=2", bus.count); end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    bus.flush    = 1'b0;
    bus.in_en    = 1'b0;
    bus.in_valid = 2'b00;
    bus.in_data  = '0;
    bus.pop_num  = 2'd0;
    test_reset();
    test_push_basic();
    test_compaction();
    test_full();
    test_wrap();
    test_underflow();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Parametrised fetch-to-decode instruction queue; successor to the dual-FIFO instruction buffer.
- A single circular queue with FETCH_W write lanes and ISSUE_W read lanes.
- Push compacts out invalid fetch slots, so bubbles never reach decode. Pop is a variable-count in-order dequeue driven by the decoder.
- Sits between the ICache/branch-predictor return path and the decode/dispatch stage.

Parameters:
- DEPTH, 16, queue entries; power of two, >= 2*FETCH_W.
- ENTRY_W, 106, bits per entry: {valid, pred_taken, pred_addr, pc, inst, exc, exc_cause}.
- FETCH_W, 2, push lanes per cycle.
- ISSUE_W, 2, pop lanes per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous clear of all entries.
- in_en  in  1  fetch packet present (icache valid).
- in_valid  in  FETCH_W  per-lane instruction valid.
- in_data  in  FETCH_W*ENTRY_W  lane i at bits [i*ENTRY_W +: ENTRY_W].
- pop_num  in  $clog2(ISSUE_W+1)  number of entries decode consumes this cycle.
- out_data  out  ISSUE_W*ENTRY_W  oldest ISSUE_W entries, lane 0 oldest.
- out_valid  out  ISSUE_W  thermometer code: lane i valid iff count > i.
- count  out  $clog2(DEPTH+1)  current occupancy.
- stall  out  1  fetch must hold; asserted when free slots < FETCH_W.

Behaviour:
- State: head pointer, tail pointer ($clog2(DEPTH) bits, natural wrap), count register, DEPTH x ENTRY_W storage.
- Reset (rst=0, async): head=tail=count=0. out_valid=0, stall=0, count=0. out_data is don't-care but driven from storage (no X on out_valid).
- Push accepted iff in_en=1 and stall=0.
  - Lanes with in_valid[i]=1 are written in lane order to tail, tail+1, ... (compaction). Lane 0 is always written before lane 1.
  - npush = popcount(in_valid & {FETCH_W{in_en & !stall}}); tail advances by npush.
  - in_en=1 with in_valid=0 accepts nothing.
  - Push while stall=1 is dropped. Fetch is required to hold, so no data is lost.
- stall is combinational from the registered count only: stall = (DEPTH - count) < FETCH_W. A same-cycle pop does not free space for a same-cycle push; this is conservative by design and avoids a pop->push timing path.
- Pop:
  - npop = min(pop_num, count); head advances by npop.
  - pop_num > count is legal and is clamped.
  - pop_num > ISSUE_W is illegal; the behaviour is to clamp it to ISSUE_W.
- out_data lane i = storage[head+i], combinational read, zero latency. Data pushed in cycle N is visible on out_data in cycle N+1.
- Simultaneous push and pop: count_next = count + npush - npop. No overflow is possible because of the stall rule.
- Wrap-around: pointer arithmetic is modulo DEPTH. Entries straddling index DEPTH-1 -> 0 pop correctly in order.
- flush=1 has priority over push and pop: head=tail=count=0 next cycle, and the push/pop in that cycle is discarded.
- Full: count=DEPTH-FETCH_W+1 .. DEPTH gives stall=1. Empty: count=0 gives out_valid=0, and any pop is a no-op.
- Reset asserted mid-operation clears immediately (async); the first push is accepted on the first rising clk after rst deasserts.
- Entry bit[ENTRY_W-1] (valid) is stored verbatim. Compaction guarantees it is 1 for every entry actually pushed.

Optional Feature:
- Macro INST_QUEUE_PERF_EN.
- Defined:
  - Adds output full_cycles (32) and output flush_cnt (32).
  - full_cycles increments each clk with stall=1.
  - flush_cnt increments each flush.
  - Both counters wrap at 2^32 and reset to 0 on rst; flush does not clear them.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then push {in_valid=2'b11, pc 0x1c000000/0x1c000004}, pop_num=0 -> next cycle count=2, out_valid=2'b11, lane0 pc=0x1c000000.
- Push in_valid=2'b10 (lane1 pc 0x1c000014) into an empty queue -> count=1; out_data lane0 pc=0x1c000014 (compacted), out_valid=2'b01.
- DEPTH=8: push 2 per cycle for 4 cycles with no pop -> count=8, stall=1. With stall held, push is dropped (count stays 8); pop_num=1 -> count=7, stall=1 (7 > 6); next pop_num=1 -> count=6, stall=0.
- Fill 6, pop 2 per cycle while pushing 2 per cycle for 10 cycles -> pointers wrap. Output pcs strictly sequential with no duplicates or skips; count constant at 6.
- count=1, pop_num=2 -> count=0, out_valid=0; a further pop_num=2 keeps count=0.
- count=5 with push and pop in the same cycle as flush=1 -> next cycle count=0, out_valid=0, stall=0. With INST_QUEUE_PERF_EN, flush_cnt=1.
